// File: rtl/sensor_conditioner_if.sv
// Detector bus between raw loop/beam sensors and the entry-counter front end.
//   D1Raw/D2Raw : raw detector levels, asynchronous to the system clock
//   D1/D2       : clean qualified levels for the counting FSM
//   Fault1/2    : sticky stuck-active flags
//   SimulEdge   : one-cycle pulse when D1 and D2 change on the same edge
// master = sensor/consumer side, slave = conditioner.
interface sensor_conditioner_if;
  logic D1Raw;
  logic D2Raw;
  logic D1;
  logic D2;
  logic Fault1;
  logic Fault2;
  logic SimulEdge;

  modport master (
    output D1Raw, D2Raw,
    input  D1, D2, Fault1, Fault2, SimulEdge
  );

  modport slave (
    input  D1Raw, D2Raw,
    output D1, D2, Fault1, Fault2, SimulEdge
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Two-channel detector conditioner: 2-flop sync, consecutive-cycle debounce
// and stuck-active watchdog per channel, plus a simultaneous-change flag.
//   Clk : system clock, rising edge
//   Rst : synchronous active-high reset
//   io  : sensor_conditioner_if.slave (raw inputs, clean levels, flags)
module sensor_conditioner #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned DEB_W        = 4,
  parameter int unsigned STUCK_CYCLES = 50000,
  parameter int unsigned STUCK_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  sensor_conditioner_if.slave   io
);

  localparam int unsigned NCH = 2;
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

  logic [NCH-1:0]              raw;
  logic [NCH-1:0]              s1;
  logic [NCH-1:0]              s2;
  logic [NCH-1:0]              q;
  logic [NCH-1:0]              q_nxt;
  logic [NCH-1:0]              fault;
  logic [NCH-1:0]              fault_nxt;
  logic [NCH-1:0]              d;
  logic [NCH-1:0]              d_nxt;
  logic [NCH-1:0][DEB_W-1:0]   deb_cnt;
  logic [NCH-1:0][DEB_W-1:0]   deb_nxt;
  logic [NCH-1:0][STUCK_W-1:0] stuck_cnt;
  logic [NCH-1:0][STUCK_W-1:0] stuck_nxt;
  logic                        simul;
  logic                        simul_nxt;

  assign raw = {io.D2Raw, io.D1Raw};

  // Next-state for debounce, watchdog and clean outputs of both channels
  always_comb begin
    q_nxt     = q;
    fault_nxt = fault;
    deb_nxt   = deb_cnt;
    stuck_nxt = stuck_cnt;
    for (int i = 0; i < int'(NCH); i++) begin
      if (s2[i] == q[i]) begin
        deb_nxt[i] = '0;
      end else if (deb_cnt[i] == DEB_LAST) begin
        q_nxt[i]   = s2[i];
        deb_nxt[i] = '0;
      end else begin
        deb_nxt[i] = deb_cnt[i] + DEB_W'(1);
      end

      // Watchdog runs on the current qualified level; it saturates once faulted
      if (!q[i]) begin
        stuck_nxt[i] = '0;
      end else if (!fault[i]) begin
        if (stuck_cnt[i] == STUCK_LAST) fault_nxt[i] = 1'b1;
        else                            stuck_nxt[i] = stuck_cnt[i] + STUCK_W'(1);
      end

      // A qualified 0 releases the sticky fault on the same edge
      if (!q_nxt[i]) fault_nxt[i] = 1'b0;
    end
    d_nxt     = q_nxt & ~fault_nxt;
    simul_nxt = &(d_nxt ^ d);
  end

  // State registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1        <= '0;
      s2        <= '0;
      q         <= '0;
      fault     <= '0;
      d         <= '0;
      deb_cnt   <= '0;
      stuck_cnt <= '0;
      simul     <= 1'b0;
    end else begin
      s1        <= raw;
      s2        <= s1;
      q         <= q_nxt;
      fault     <= fault_nxt;
      d         <= d_nxt;
      deb_cnt   <= deb_nxt;
      stuck_cnt <= stuck_nxt;
      simul     <= simul_nxt;
    end
  end

  assign io.D1        = d[0];
  assign io.D2        = d[1];
  assign io.Fault1    = fault[0];
  assign io.Fault2    = fault[1];
  assign io.SimulEdge = simul;

endmodule
